uart_frame_parser: RTL and testbench

- Downstream of the UART controller's receive path; consumes one received byte per `rx_valid` strobe.
- Recovers framed packets of the form: SOF, LEN, LEN payload bytes, CHK.
- Payload is held internally until the checksum passes, then streamed out on a valid/ready interface.
- Malformed, corrupt or stalled frames are dropped and flagged with an error code.

---
 rtl/uart_frame_pkg.sv | 22 ++
 rtl/uart_frame_if.sv | 32 +++
 rtl/uart_frame_buf.sv | 28 ++
 rtl/uart_frame_parser.sv | 199 +++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: FSM states, drop
// causes and the default start-of-frame marker.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_CHK     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_if.sv
// Byte-in / payload-out stream bundle of the frame parser. The parser sits on
// the master side; the UART receiver and payload consumer sit on the slave side.
interface uart_frame_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] payload_data;
    logic                 payload_valid;
    logic                 payload_last;
    logic                 payload_ready;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  payload_ready,
        output payload_data,
        output payload_valid,
        output payload_last
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output payload_ready,
        input  payload_data,
        input  payload_valid,
        input  payload_last
    );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: register array with one synchronous write port and
// one combinational read port.
module uart_frame_buf #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; a byte is only read after it was
    // written in the current frame, and the top masks the read data when idle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Recovers SOF/LEN/payload/CHK frames from a received byte stream, buffers the
// payload until the checksum passes, then streams it out with valid/ready.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int                   DATA_BITS      = 8,
    parameter int                   MAX_PAYLOAD    = 16,
    parameter logic [DATA_BITS-1:0] SOF_BYTE       = DATA_BITS'(DEFAULT_SOF_BYTE),
    parameter int                   TIMEOUT_CYCLES = 100000
) (
    input  logic                               clk,
    input  logic                               reset,
    uart_frame_if.master                       bus,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   frame_len,
    output logic                               frame_ok,
    output logic                               frame_err,
    output logic [1:0]                         err_code,
    output logic                               rx_overrun,
    output logic                               busy
);

    localparam int LEN_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int ADDR_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q,   state_d;
    logic [LEN_W-1:0]     len_q,     len_d;
    logic [DATA_BITS-1:0] acc_q,     acc_d;
    logic [LEN_W-1:0]     wr_idx_q,  wr_idx_d;
    logic [LEN_W-1:0]     rd_idx_q,  rd_idx_d;
    logic [TMO_W-1:0]     tmo_q,     tmo_d;
    logic [LEN_W-1:0]     flen_q,    flen_d;
    err_code_t            code_q,    code_d;
    logic                 ok_q,      ok_d;
    logic                 err_q,     err_d;
    logic                 ovr_q,     ovr_d;
    logic                 buf_we;

    logic [DATA_BITS-1:0] acc_sum;
    logic [DATA_BITS-1:0] buf_rd;
    logic                 in_frame;
    logic                 tmo_expired;
    logic                 len_ok;
    logic                 rd_last;

    uart_frame_buf #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (MAX_PAYLOAD),
        .ADDR_W    (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_addr (wr_idx_q[ADDR_W-1:0]),
        .wr_data (bus.rx_data),
        .rd_addr (rd_idx_q[ADDR_W-1:0]),
        .rd_data (buf_rd)
    );

    assign acc_sum     = acc_q + bus.rx_data;
    assign in_frame    = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_expired = in_frame && !bus.rx_valid && (tmo_q == TMO_LAST);
    assign len_ok      = (bus.rx_data != '0) && (int'(bus.rx_data) <= MAX_PAYLOAD);
    assign rd_last     = (rd_idx_q == len_q - LEN_ONE);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        acc_d    = acc_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        flen_d   = flen_q;
        code_d   = code_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
        buf_we   = 1'b0;
        tmo_d    = '0;

        if (in_frame && !bus.rx_valid) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data == SOF_BYTE) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (bus.rx_valid) begin
                    if (len_ok) begin
                        len_d    = LEN_W'(bus.rx_data);
                        acc_d    = bus.rx_data;
                        wr_idx_d = '0;
                        state_d  = PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = IDLE;
                    end
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = IDLE;
                end
            end
            PAYLOAD: begin
                if (bus.rx_valid) begin
                    buf_we = 1'b1;
                    acc_d  = acc_sum;
                    if (wr_idx_q == len_q - LEN_ONE) begin
                        state_d = CHK;
                    end else begin
                        wr_idx_d = wr_idx_q + LEN_ONE;
                    end
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = IDLE;
                end
            end
            CHK: begin
                if (bus.rx_valid) begin
                    if (acc_sum == '0) begin
                        ok_d     = 1'b1;
                        flen_d   = len_q;
                        rd_idx_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = IDLE;
                    end
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                ovr_d = bus.rx_valid;
                if (bus.payload_ready) begin
                    if (rd_last) begin
                        rd_idx_d = '0;
                        state_d  = IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + LEN_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every register here is updated with <= so all of them see the same
    // pre-edge values computed by the combinational block above.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            acc_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            tmo_q    <= '0;
            flen_q   <= '0;
            code_q   <= ERR_NONE;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            tmo_q    <= tmo_d;
            flen_q   <= flen_d;
            code_q   <= code_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.payload_valid = (state_q == DRAIN);
    assign bus.payload_data  = (state_q == DRAIN) ? buf_rd : '0;
    assign bus.payload_last  = (state_q == DRAIN) && rd_last;

    assign frame_len  = flen_q;
    assign frame_ok   = ok_q;
    assign frame_err  = err_q;
    assign err_code   = code_q;
    assign rx_overrun = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected payload bytes and frame
// events are queued as stimulus is sent and retired as the DUT emits them.
module tb_uart_frame_parser;

    import uart_frame_pkg::*;

    localparam int DB    = 8;
    localparam int MP    = 16;
    localparam int TC    = 50;
    localparam int LW    = $clog2(MP + 1);

    typedef struct {
        logic [DB-1:0] d;
        logic          last;
    } pl_t;

    typedef struct {
        logic          is_err;
        logic [1:0]    code;
        logic [LW-1:0] len;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_if #(.DATA_BITS(DB)) bus ();

    logic [LW-1:0] frame_len;
    logic          frame_ok;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          rx_overrun;
    logic          busy;

    uart_frame_parser #(
        .DATA_BITS      (DB),
        .MAX_PAYLOAD    (MP),
        .SOF_BYTE       (8'hA5),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .bus        (bus),
        .frame_len  (frame_len),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .rx_overrun (rx_overrun),
        .busy       (busy)
    );

    int  total = 0;
    int  bad = 0;
    int  ovr_seen = 0;
    pl_t pl_q[$];
    ev_t ev_q[$];
    pl_t pl_e;
    ev_t ev_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [DB-1:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_pl(input logic [DB-1:0] d, input logic last);
        pl_t e;
        e.d    = d;
        e.last = last;
        pl_q.push_back(e);
    endtask

    task automatic expect_ev(input logic is_err, input logic [1:0] code, input logic [LW-1:0] len);
        ev_t e;
        e.is_err = is_err;
        e.code   = code;
        e.len    = len;
        ev_q.push_back(e);
    endtask

    // Builds a correct frame around p, queuing its payload and its frame_ok.
    task automatic send_good(input logic [DB-1:0] p[$]);
        logic [DB-1:0] sum;
        logic [DB-1:0] c;
        sum = DB'(p.size());
        foreach (p[i]) begin
            sum += p[i];
            expect_pl(p[i], i == p.size() - 1);
        end
        c = ~sum + 1'b1;
        expect_ev(1'b0, 2'b00, LW'(p.size()));
        send_byte(8'hA5);
        send_byte(DB'(p.size()));
        foreach (p[i]) send_byte(p[i]);
        send_byte(c);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || pl_q.size() != 0 || ev_q.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_bound", 32'(n < 500), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.payload_valid && bus.payload_ready) begin
                if (pl_q.size() == 0) begin
                    check("pl_unexpected", {24'h0, bus.payload_data}, 32'hFFFF_FFFF);
                end else begin
                    pl_e = pl_q.pop_front();
                    check("pl_data", bus.payload_data, pl_e.d);
                    check("pl_last", bus.payload_last, pl_e.last);
                end
            end
            if (frame_ok || frame_err) begin
                if (ev_q.size() == 0) begin
                    check("ev_unexpected", {frame_ok, frame_err}, 0);
                end else begin
                    ev_e = ev_q.pop_front();
                    check("ev_kind", {frame_ok, frame_err}, ev_e.is_err ? 2'b01 : 2'b10);
                    if (ev_e.is_err) check("ev_code", err_code, ev_e.code);
                    else             check("ev_len", frame_len, ev_e.len);
                end
            end
            if (rx_overrun) ovr_seen++;
        end
    end

    initial begin
        logic [DB-1:0] q[$];
        int n;

        bus.rx_data       = '0;
        bus.rx_valid      = 1'b0;
        bus.payload_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_outs", {bus.payload_valid, bus.payload_last, bus.payload_data,
                           frame_ok, frame_err, err_code, rx_overrun, frame_len}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Good frame with a literal checksum byte.
        expect_pl(8'h11, 1'b0);
        expect_pl(8'h22, 1'b0);
        expect_pl(8'h33, 1'b1);
        expect_ev(1'b0, 2'b00, LW'(3));
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
        check("ok_with_valid", {frame_ok, bus.payload_valid}, 2'b11);
        check("first_byte", bus.payload_data, 8'h11);
        wait_idle();
        check("good_no_err", err_code, 2'b00);
        check("good_valid_low", bus.payload_valid, 0);

        // Bad checksum: error only, no payload.
        expect_ev(1'b1, 2'b10, '0);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h98);
        wait_idle();
        check("chk_code_hold", err_code, 2'b10);

        // Bad lengths, each followed immediately by the next SOF.
        expect_ev(1'b1, 2'b01, '0);
        send_byte(8'hA5); send_byte(8'h00);
        expect_ev(1'b1, 2'b01, '0);
        send_byte(8'hA5); send_byte(8'h11);
        expect_pl(8'h7F, 1'b1);
        expect_ev(1'b0, 2'b00, LW'(1));
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        wait_idle();
        check("len1_frame_len", frame_len, 1);

        // Timeout latency, counted from the edge that took the last byte.
        expect_ev(1'b1, 2'b11, '0);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        n = 0;
        while (!frame_err && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tmo_latency", n, TC);
        wait_idle();
        check("tmo_code", err_code, 2'b11);

        // A byte landing exactly on the expiry cycle keeps the frame alive.
        expect_pl(8'h11, 1'b0);
        expect_pl(8'h22, 1'b0);
        expect_pl(8'h33, 1'b1);
        expect_ev(1'b0, 2'b00, LW'(3));
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        repeat (TC - 1) @(posedge clk);
        #1;
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
        wait_idle();
        check("edge_code_hold", err_code, 2'b11);

        // Backpressure on the second byte plus one overrun byte during drain.
        ovr_seen = 0;
        expect_pl(8'h11, 1'b0);
        expect_pl(8'h22, 1'b0);
        expect_pl(8'h33, 1'b1);
        expect_ev(1'b0, 2'b00, LW'(3));
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
        @(posedge clk);
        #1;
        bus.payload_ready = 1'b0;
        bus.rx_data       = 8'h5A;
        bus.rx_valid      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.rx_valid = 1'b0;
            check("bp_data", bus.payload_data, 8'h22);
            check("bp_valid", bus.payload_valid, 1);
        end
        bus.payload_ready = 1'b1;
        wait_idle();
        check("ovr_count", ovr_seen, 1);

        // Garbage ahead of a good frame.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check("garbage_idle", busy, 0);
        q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_good(q);
        wait_idle();

        // Reset in the middle of a payload.
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_outs", {bus.payload_valid, bus.payload_last, bus.payload_data,
                               frame_ok, frame_err, err_code, rx_overrun, frame_len}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q = {8'h01, 8'hFE};
        send_good(q);
        wait_idle();

        check("pl_q_empty", pl_q.size(), 0);
        check("ev_q_empty", ev_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
